// File: rtl/raw_tr_edge_meter.sv
// Edge meter for digitized analog nodes: synchronizes sense_in, counts rising
// edges over a programmable gate window, then streams the count out byte-serially.
module raw_tr_edge_meter #(
    parameter int GATE_W = 16,
    parameter int CNT_W  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sense_in,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              rd_req,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [7:0]        data_out,
    output logic              data_valid
);

    localparam int NBYTES = CNT_W / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_COUNT,
        S_HOLD
    } state_t;

    state_t            r_state;
    logic              r_s1, r_s2, r_s3;
    logic [GATE_W-1:0] r_timer;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_busy;
    logic              r_done;
    logic              r_ovf;
    logic [7:0]        r_dout;
    logic              r_dvalid;

    logic              w_edge;
    logic              w_launch;
    logic              w_last_byte;
    logic [CNT_W-1:0]  w_shifted;

    assign w_edge      = r_s2 & ~r_s3;
    assign w_launch    = start & ((r_state == S_IDLE) | (r_state == S_HOLD));
    assign w_last_byte = (r_idx == IDX_W'(NBYTES - 1));
    assign w_shifted   = r_cnt >> {r_idx, 3'b000};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_s3     <= 1'b0;
            r_timer  <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_dout   <= '0;
            r_dvalid <= 1'b0;
        end else begin
            r_s1     <= sense_in;
            r_s2     <= r_s1;
            r_s3     <= r_s2;
            r_dvalid <= 1'b0;

            // start from HOLD aborts read-out and takes priority over rd_req
            if (w_launch) begin
                r_timer <= gate_len;
                r_ovf   <= 1'b0;
                r_cnt   <= '0;
                r_idx   <= '0;
                if (gate_len == '0) begin
                    r_state <= S_HOLD;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= S_ARM;
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_busy <= 1'b0;
                        r_done <= 1'b0;
                    end
                    S_ARM: begin
                        r_cnt   <= '0;
                        r_state <= S_COUNT;
                    end
                    S_COUNT: begin
                        if (w_edge) begin
                            if (r_cnt == '1) begin
                                r_ovf <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                        if (r_timer == GATE_W'(1)) begin
                            r_state <= S_HOLD;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (rd_req) begin
                            r_dout   <= w_shifted[7:0];
                            r_dvalid <= 1'b1;
                            if (w_last_byte) begin
                                r_idx   <= '0;
                                r_state <= S_IDLE;
                                r_done  <= 1'b0;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign overflow   = r_ovf;
    assign data_out   = r_dout;
    assign data_valid = r_dvalid;

endmodule

// File: tb/tb_raw_tr_edge_meter.sv
// Bench for raw_tr_edge_meter: directed and randomized measurements on a 24-bit
// and an 8-bit instance, checked against a sample-history edge-count model.
module tb_raw_tr_edge_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sense_in = 1'b0;
    logic        start = 1'b0;
    logic        rd_req = 1'b0;
    logic [15:0] gate_len = '0;
    logic        sel8 = 1'b0;

    logic        busy24, done24, ovf24, dv24;
    logic [7:0]  dout24;
    logic        busy8, done8, ovf8, dv8;
    logic [7:0]  dout8;

    logic        o_busy, o_done, o_ovf, o_dv;
    logic [7:0]  o_dout;

    int tests = 0;
    int fails = 0;

    // one entry per clock edge: the sense_in value the DUT sampled at that edge
    bit hist[$];
    int mode = 0;
    int per = 4;
    int ph = 0;

    always #5 clk = ~clk;
    always @(posedge clk) hist.push_back(sense_in);

    raw_tr_edge_meter #(.GATE_W(16), .CNT_W(24)) u_dut24 (
        .clk(clk), .rst_n(rst_n), .sense_in(sense_in),
        .start(start & ~sel8), .gate_len(gate_len), .rd_req(rd_req & ~sel8),
        .busy(busy24), .done(done24), .overflow(ovf24),
        .data_out(dout24), .data_valid(dv24)
    );

    raw_tr_edge_meter #(.GATE_W(16), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .sense_in(sense_in),
        .start(start & sel8), .gate_len(gate_len), .rd_req(rd_req & sel8),
        .busy(busy8), .done(done8), .overflow(ovf8),
        .data_out(dout8), .data_valid(dv8)
    );

    assign o_busy = sel8 ? busy8 : busy24;
    assign o_done = sel8 ? done8 : done24;
    assign o_ovf  = sel8 ? ovf8  : ovf24;
    assign o_dv   = sel8 ? dv8   : dv24;
    assign o_dout = sel8 ? dout8 : dout24;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance one clock; pulses drop, sense_in gets its value for the next edge
    task automatic cycle();
        int n;
        @(posedge clk);
        #1;
        start  = 1'b0;
        rd_req = 1'b0;
        n = hist.size();
        if (mode == 0) sense_in = (((n + ph) % per) >= (per / 2));
        else           sense_in = $urandom_range(0, 1);
    endtask

    // rises seen at samples S..S+G-1 fall inside the gate after the 3-flop delay
    function automatic int model_cnt(input int s, input int g, input int w, output bit ovf);
        longint n;
        longint mx;
        n  = 0;
        mx = (longint'(1) << w) - 1;
        for (int j = s; j < s + g; j++)
            if (hist[j] && !hist[j-1]) n++;
        ovf = (n > mx);
        return (n > mx) ? int'(mx) : int'(n);
    endfunction

    task automatic launch(input int g, output int s);
        gate_len = g[15:0];
        start = 1'b1;
        s = hist.size();
        cycle();
    endtask

    task automatic wait_done(input int g, input bit inject, input string tg);
        int  bc;
        bit  got;
        bc  = 0;
        got = 1'b0;
        for (int k = 0; k < g + 20; k++) begin
            if (o_done) begin
                got = 1'b1;
                break;
            end
            if (o_busy) bc++;
            if (inject && o_busy && (k % 7 == 3)) begin
                start    = 1'b1;
                rd_req   = 1'b1;
                gate_len = 16'd3;
            end
            cycle();
            gate_len = g[15:0];
        end
        chk({tg, "_done_rise"}, got, 1);
        chk({tg, "_busy_cycles"}, bc, (g == 0) ? 0 : g + 1);
    endtask

    task automatic read_bytes(input int nb, input logic [23:0] expv, input bit b2b, input string tg);
        logic [23:0] sh;
        for (int i = 0; i < nb; i++) begin
            sh = expv >> (8 * i);
            rd_req = 1'b1;
            cycle();
            chk({tg, "_dv"}, o_dv, 1);
            chk({tg, "_byte"}, o_dout, sh[7:0]);
            chk({tg, "_done_rd"}, o_done, (i == nb - 1) ? 0 : 1);
            if (!b2b) begin
                cycle();
                chk({tg, "_dv_gap"}, o_dv, 0);
                chk({tg, "_hold"}, o_dout, sh[7:0]);
            end
        end
        cycle();
        chk({tg, "_dv_end"}, o_dv, 0);
        chk({tg, "_done_end"}, o_done, 0);
        chk({tg, "_busy_end"}, o_busy, 0);
    endtask

    initial begin
        int   s, s2, e, g;
        bit   ov;
        logic [23:0] ev;

        // reset state
        rst_n = 1'b0;
        repeat (3) cycle();
        chk("rst_busy", busy24, 0);
        chk("rst_done", done24, 0);
        chk("rst_ovf", ovf24, 0);
        chk("rst_dout", dout24, 0);
        chk("rst_dv", dv24, 0);
        chk("rst_done8", done8, 0);
        rst_n = 1'b1;
        cycle();

        // square wave period 4, gate 100
        mode = 0; per = 4; ph = 0;
        repeat (6) cycle();
        launch(100, s);
        wait_done(100, 1'b0, "sq100");
        chk("sq100_ovf", o_ovf, 0);
        read_bytes(3, 24'd25, 1'b0, "sq100");

        // rd_req in IDLE is ignored
        rd_req = 1'b1;
        cycle();
        chk("idle_rd_dv", o_dv, 0);

        // zero-length gate
        launch(0, s);
        chk("g0_done", o_done, 1);
        chk("g0_busy", o_busy, 0);
        wait_done(0, 1'b0, "g0");
        read_bytes(3, 24'd0, 1'b1, "g0");

        // 8-bit counter saturation
        sel8 = 1'b1;
        per = 2;
        repeat (4) cycle();
        launch(600, s);
        wait_done(600, 1'b0, "sat");
        chk("sat_ovf", o_ovf, 1);
        read_bytes(1, 24'hFF, 1'b0, "sat");
        chk("sat_ovf_sticky", o_ovf, 1);
        launch(5, s);
        chk("sat_ovf_clr", o_ovf, 0);
        wait_done(5, 1'b0, "sat2");
        e = model_cnt(s, 5, 8, ov);
        chk("sat2_ovf", o_ovf, 0);
        read_bytes(1, e[23:0], 1'b1, "sat2");
        sel8 = 1'b0;

        // aligned gate 50 with start/rd_req pulses injected during COUNT
        per = 4; ph = 1;
        repeat (4) cycle();
        while (((hist.size() + ph) % 4) != 2) cycle();
        launch(50, s);
        wait_done(50, 1'b1, "al50");
        read_bytes(3, 24'd13, 1'b0, "al50");

        // unaligned gate 50 with injection, checked against the model
        ph = 3;
        repeat (3) cycle();
        launch(50, s);
        wait_done(50, 1'b1, "ua50");
        e = model_cnt(s, 50, 24, ov);
        read_bytes(3, e[23:0], 1'b1, "ua50");

        // start during read-out restarts measurement, and beats a same-cycle rd_req
        mode = 1;
        launch(200, s);
        wait_done(200, 1'b0, "ab1");
        e = model_cnt(s, 200, 24, ov);
        rd_req = 1'b1;
        cycle();
        chk("ab1_byte0", o_dout, e[7:0]);
        gate_len = 16'd150;
        start  = 1'b1;
        rd_req = 1'b1;
        s2 = hist.size();
        cycle();
        chk("ab_start_wins_dv", o_dv, 0);
        chk("ab_restart_busy", o_busy, 1);
        wait_done(150, 1'b0, "ab2");
        e = model_cnt(s2, 150, 24, ov);
        read_bytes(3, e[23:0], 1'b1, "ab2");

        // reset in the middle of COUNT
        mode = 0; per = 4; ph = 0;
        launch(100, s);
        repeat (30) cycle();
        chk("mr_busy_pre", o_busy, 1);
        rst_n = 1'b0;
        cycle();
        chk("mr_busy", busy24, 0);
        chk("mr_done", done24, 0);
        chk("mr_ovf", ovf24, 0);
        chk("mr_dout", dout24, 0);
        chk("mr_dv", dv24, 0);
        rst_n = 1'b1;
        cycle();
        chk("mr_idle_done", o_done, 0);
        chk("mr_idle_busy", o_busy, 0);
        launch(100, s);
        wait_done(100, 1'b0, "mr100");
        read_bytes(3, 24'd25, 1'b1, "mr100");

        // randomized measurements
        for (int r = 0; r < 8; r++) begin
            mode = (r % 3 == 0) ? 0 : 1;
            per  = 2 * $urandom_range(1, 5);
            ph   = $urandom_range(0, 9);
            g    = (r == 4) ? 0 : $urandom_range(1, 300);
            repeat ($urandom_range(1, 5)) cycle();
            launch(g, s);
            wait_done(g, r[0], "rnd");
            e = model_cnt(s, g, 24, ov);
            chk("rnd_ovf", o_ovf, ov);
            ev = e[23:0];
            read_bytes(3, ev, r[1], "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/raw_tr_edge_meter.md
Name: raw_tr_edge_meter

Overview:
- Digital read-out end for the raw-transistor analog cells. It measures the response of a device under test, such as a ring oscillator or comparator output.
- A digitized analog node enters on `sense_in`. The block synchronizes it and counts rising edges during a programmable gate window of clock cycles.
- The result is returned as a byte-serial stream under a request/valid handshake, for the dedicated digital outputs.
- Sits between the analog pin (via a comparator/buffer) and the top-level `uo_out`/`uio` wiring.

Parameters:
- `GATE_W`, 16, width of gate length in clock cycles.
- `CNT_W`, 24, edge counter width; must be a multiple of 8. `NBYTES = CNT_W/8`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `sense_in`  in  1  asynchronous digitized analog node.
- `start`  in  1  one-cycle pulse, begin measurement.
- `gate_len`  in  `GATE_W`  gate length in cycles, sampled on accepted `start`.
- `rd_req`  in  1  one-cycle pulse, request next result byte.
- `busy`  out  1  high in `ARM` and `COUNT`.
- `done`  out  1  high in `HOLD` (result available).
- `overflow`  out  1  counter saturated during last measurement.
- `data_out`  out  8  result byte.
- `data_valid`  out  1  one-cycle pulse, `data_out` valid.

Behaviour:
- Reset (`rst_n` low at a `clk` edge): state `IDLE`. `busy`, `done`, `overflow`, `data_valid` = 0; `data_out` = 0; counter, gate timer and byte index = 0; synchronizer flops = 0. Reset mid-operation aborts immediately and discards any result.
- Input path:
  - 2-FF synchronizer on `sense_in`, then a third flop for edge detect.
  - `edge_det = s2 & ~s3`.
  - A `sense_in` rise is seen as `edge_det` 3 clocks later (fixed latency, not compensated).
- `IDLE`:
  - On `start`: latch `gate_len` into the gate timer, clear `overflow`.
  - If `gate_len == 0`: go to `HOLD` with count 0. Otherwise go to `ARM`.
- `ARM` (1 cycle): clear counter, go to `COUNT`.
- `COUNT`:
  - Lasts exactly `gate_len` cycles. Timer decrements each cycle; leave to `HOLD` in the cycle the timer reaches 1.
  - Counter increments on each cycle where `edge_det == 1`.
  - On saturation the counter holds at all-ones and `overflow` is set, sticky until the next accepted `start`.
  - `start` is ignored in `ARM`/`COUNT`.
- `HOLD`: `done = 1`, result frozen.
  - Each `rd_req` drives the next byte, LSB first: `data_out = count[8*i+7:8*i]` with `data_valid = 1` on the following cycle. `i` increments.
  - After byte `NBYTES-1` is delivered, go to `IDLE`; `done` falls in the same cycle `data_valid` is high.
  - `rd_req` while `data_valid` is already high is accepted (back-to-back reads allowed, one byte per cycle).
  - `rd_req` outside `HOLD` is ignored; no `data_valid`.
  - `start` in `HOLD` aborts read-out: byte index is reset and a new measurement begins exactly as from `IDLE`. If `start` and `rd_req` arrive in the same cycle, `start` wins.
- `data_out` holds its last value between pulses.
- All arithmetic is unsigned; gate timer and counter never wrap.

Test Plan:
- Square wave on `sense_in`, period 4 clk, running before `start`; `gate_len = 100` -> `busy` for 101 cycles, `done` rises. Three `rd_req` pulses give 0x19, 0x00, 0x00; `overflow = 0`.
- `gate_len = 0`, `start` -> `done = 1` one cycle later, `busy` never asserts. Read-out gives 0x00 ×3; afterwards state is `IDLE` and `done = 0`.
- `CNT_W = 8`, `sense_in` period 2, `gate_len = 600` -> count holds 0xFF, `overflow = 1`. Next `start` clears `overflow`.
- During `COUNT` (`gate_len = 50`, period 4): extra `start` pulses and `rd_req` pulses -> no effect; result 12 or 13 only as set by phase. With `sense_in` aligned so the first edge lands in cycle 1 of `COUNT`, the result is exactly 13.
- After 1 of 3 bytes read, pulse `start` -> new measurement runs; first subsequent read returns byte 0 of the new result.
- Assert `rst_n = 0` mid-`COUNT` -> next cycle all outputs 0, state `IDLE`. A following `start` with `gate_len = 100`, period 4 -> result 25.
